// File: rtl/ras_stack.sv
// Return-address stack for call/return target prediction.
// Circular array of RAS_DEPTH entries with a top-of-stack pointer and a
// saturating valid-entry count. Pointer and count can be checkpointed
// through ras_index/ras_count and later restored. Overflow overwrites the
// oldest entry, and underflow still moves the pointer.
//
// Ports:
//   CLK            rising-edge clock for all state
//   RST            synchronous active-high reset (overrides everything)
//   push_valid     push push_target as the new top
//   push_target    return address to push
//   pop_valid      pop the top entry
//   pop_target     current top entry, combinational read of array[ptr]
//   pop_empty      high when the count is zero
//   ras_index      current top-of-stack pointer
//   ras_count      current valid-entry count
//   restore_valid  load pointer/count from a checkpoint (overrides push/pop)
//   restore_index  checkpointed pointer
//   restore_count  checkpointed count, clamped to RAS_DEPTH
module ras_stack #(
    parameter int unsigned RAS_DEPTH        = 8,
    parameter int unsigned RAS_TARGET_WIDTH = 12,
    parameter int unsigned LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    output logic [RAS_TARGET_WIDTH-1:0] pop_target,
    output logic                        pop_empty,
    output logic [LOG_RAS_DEPTH-1:0]    ras_index,
    output logic [LOG_RAS_DEPTH:0]      ras_count,
    input  logic                        restore_valid,
    input  logic [LOG_RAS_DEPTH-1:0]    restore_index,
    input  logic [LOG_RAS_DEPTH:0]      restore_count
);

    localparam int unsigned CW = LOG_RAS_DEPTH + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [RAS_TARGET_WIDTH-1:0] mem [RAS_DEPTH];
    logic [LOG_RAS_DEPTH-1:0]    ptr_q;
    logic [LOG_RAS_DEPTH-1:0]    ptr_n;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_n;
    logic                        wr_en;
    logic [LOG_RAS_DEPTH-1:0]    wr_addr;

    // Next pointer/count and array write; restore beats push/pop.
    always_comb begin
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        if (restore_valid) begin
            ptr_n = restore_index;
            cnt_n = (restore_count > FULL) ? FULL : restore_count;
        end else if (push_valid && pop_valid) begin
            // Return immediately followed by a call: replace the top in place.
            wr_en = 1'b1;
            cnt_n = (cnt_q == '0) ? CW'(1) : cnt_q;
        end else if (push_valid) begin
            ptr_n   = ptr_q + LOG_RAS_DEPTH'(1);
            wr_en   = 1'b1;
            wr_addr = ptr_q + LOG_RAS_DEPTH'(1);
            cnt_n   = (cnt_q == FULL) ? FULL : cnt_q + CW'(1);
        end else if (pop_valid) begin
            // Pointer moves even when empty so speculative underflow stays symmetric.
            ptr_n = ptr_q - LOG_RAS_DEPTH'(1);
            cnt_n = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        end
    end

    // State registers and array storage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_n;
            cnt_q <= cnt_n;
            if (wr_en) begin
                mem[wr_addr] <= push_target;
            end
        end
    end

    assign pop_target = mem[ptr_q];
    assign pop_empty  = (cnt_q == '0);
    assign ras_index  = ptr_q;
    assign ras_count  = cnt_q;

endmodule

// File: tb/tb_ras_stack.sv
// Testbench for ras_stack: directed scenarios plus random traffic, checked
// by a scoreboard fed from a behavioural model of the stack.
module tb_ras_stack;

    localparam int DEPTH = 8;
    localparam int TW    = 12;
    localparam int LW    = 3;

    logic          CLK;
    logic          RST;
    logic          push_valid;
    logic [TW-1:0] push_target;
    logic          pop_valid;
    logic [TW-1:0] pop_target;
    logic          pop_empty;
    logic [LW-1:0] ras_index;
    logic [LW:0]   ras_count;
    logic          restore_valid;
    logic [LW-1:0] restore_index;
    logic [LW:0]   restore_count;

    ras_stack #(.RAS_DEPTH(DEPTH), .RAS_TARGET_WIDTH(TW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .push_valid    (push_valid),
        .push_target   (push_target),
        .pop_valid     (pop_valid),
        .pop_target    (pop_target),
        .pop_empty     (pop_empty),
        .ras_index     (ras_index),
        .ras_count     (ras_count),
        .restore_valid (restore_valid),
        .restore_index (restore_index),
        .restore_count (restore_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int tgt;
        int emp;
        int idx;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t dir_q[$];

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    bit end_checked = 1'b0;

    // Behavioural stack: plain array of return addresses, top position and count.
    int m_arr[DEPTH];
    int m_ptr;
    int m_cnt;

    task automatic model_apply(input bit rst, input bit psh, input int pt,
                               input bit pp, input bit rv, input int ri, input int rc);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_arr[i] = 0;
            m_ptr = 0;
            m_cnt = 0;
        end else if (rv) begin
            m_ptr = ri;
            m_cnt = (rc > DEPTH) ? DEPTH : rc;
        end else if (psh && pp) begin
            m_arr[m_ptr] = pt;
            if (m_cnt == 0) m_cnt = 1;
        end else if (psh) begin
            m_ptr = (m_ptr + 1) % DEPTH;
            m_arr[m_ptr] = pt;
            if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
        end else if (pp) begin
            m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
            if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue the expected outputs.
    task automatic step(input bit rst, input bit psh, input int pt, input bit pp,
                        input bit rv, input int ri, input int rc);
        exp_t e;
        RST           = rst;
        push_valid    = psh;
        push_target   = TW'(pt);
        pop_valid     = pp;
        restore_valid = rv;
        restore_index = LW'(ri);
        restore_count = (LW+1)'(rc);
        @(posedge CLK);
        model_apply(rst, psh, pt, pp, rv, ri, rc);
        e.tgt = m_arr[m_ptr];
        e.emp = (m_cnt == 0) ? 1 : 0;
        e.idx = m_ptr;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();                step(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_push(input int pt);     step(0, 1, pt, 0, 0, 0, 0); endtask
    task automatic do_pop();                  step(0, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_pushpop(input int pt);  step(0, 1, pt, 1, 0, 0, 0); endtask

    // Hand-computed expectation for the step just issued.
    task automatic expect_dir(input int tgt, input int emp, input int idx, input int cnt);
        exp_t e;
        e.tgt = tgt; e.emp = emp; e.idx = idx; e.cnt = cnt;
        dir_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against queued expectations.
    always @(negedge CLK) begin
        exp_t e;
        exp_t d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("model pop_target", int'(pop_target), e.tgt);
            chk("model pop_empty",  int'(pop_empty),  e.emp);
            chk("model ras_index",  int'(ras_index),  e.idx);
            chk("model ras_count",  int'(ras_count),  e.cnt);
            if (dir_q.size() > 0) begin
                d = dir_q.pop_front();
                chk("directed pop_target", int'(pop_target), d.tgt);
                chk("directed pop_empty",  int'(pop_empty),  d.emp);
                chk("directed ras_index",  int'(ras_index),  d.idx);
                chk("directed ras_count",  int'(ras_count),  d.cnt);
            end
        end else if (done && !end_checked) begin
            end_checked = 1'b1;
            chk("scoreboard drained", exp_q.size() + dir_q.size(), 0);
        end
    end

    initial begin
        int wait_cycles;
        RST = 1'b1; push_valid = 1'b0; push_target = '0; pop_valid = 1'b0;
        restore_valid = 1'b0; restore_index = '0; restore_count = '0;
        for (int i = 0; i < DEPTH; i++) m_arr[i] = 0;
        m_ptr = 0; m_cnt = 0;

        // Reset values and basic push/pop.
        do_reset();            expect_dir(0, 1, 0, 0);
        do_push(12'h111);
        do_push(12'h222);
        do_push(12'h333);      expect_dir(12'h333, 0, 3, 3);
        do_pop();
        do_pop();              expect_dir(12'h111, 0, 1, 1);

        // Overflow wraps onto the oldest entry; then drain.
        do_reset();
        for (int k = 1; k <= 9; k++) do_push(k);
        expect_dir(12'h009, 0, 1, 8);
        for (int k = 1; k <= 7; k++) begin
            do_pop();          expect_dir(9 - k, 0, (9 - k) % DEPTH, 8 - k);
        end
        do_pop();              expect_dir(12'h009, 1, 1, 0);

        // Underflow still moves the pointer.
        do_reset();
        do_pop();              expect_dir(0, 1, 7, 0);
        do_push(12'hABC);      expect_dir(12'hABC, 0, 0, 1);

        // Simultaneous push and pop replaces the top.
        do_reset();
        do_push(12'h111);
        do_push(12'h222);      expect_dir(12'h222, 0, 2, 2);
        do_pushpop(12'h5A5);   expect_dir(12'h5A5, 0, 2, 2);
        do_pop();              expect_dir(12'h111, 0, 1, 1);

        // Checkpoint restore after speculative push/pops; restore beats push.
        do_reset();
        do_push(12'h111);
        do_push(12'h222);      expect_dir(12'h222, 0, 2, 2);
        do_push(12'h777);
        do_pop();
        do_pop();              expect_dir(12'h111, 0, 1, 1);
        step(0, 1, 12'hFFF, 0, 1, 2, 2);  expect_dir(12'h222, 0, 2, 2);

        // Restore count clamp, then reset beating a push.
        step(0, 0, 0, 0, 1, 4, 15);       expect_dir(0, 0, 4, 8);
        step(1, 1, 12'h123, 0, 0, 0, 0);  expect_dir(0, 1, 0, 0);

        // Mid-sequence reset discards pushed entries.
        do_push(12'h0AA);
        do_push(12'h0BB);      expect_dir(12'h0BB, 0, 2, 2);
        step(1, 1, 12'h0CC, 1, 1, 5, 3);  expect_dir(0, 1, 0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bit r_rst, r_psh, r_pp, r_rv;
            r_rst = ($urandom_range(0, 99) < 2);
            r_rv  = ($urandom_range(0, 99) < 8);
            r_psh = ($urandom_range(0, 99) < 50);
            r_pp  = ($urandom_range(0, 99) < 45);
            step(r_rst, r_psh, int'($urandom_range(0, 4095)), r_pp, r_rv,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        step(0, 0, 0, 0, 0, 0, 0);
        done = 1'b1;
        wait_cycles = 0;
        while (!end_checked && wait_cycles < 20) begin
            @(posedge CLK);
            wait_cycles++;
        end
        @(posedge CLK);
        if (!end_checked) $display("FAIL scoreboard timeout: got %0d pending, expected 0", exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + (end_checked ? 0 : 1));
        $finish;
    end

endmodule

// File: doc/ras_stack.md
RAS_STACK -- requirements
Module: ras_stack

Interface
REQ-001 The block SHALL take parameter RAS_DEPTH, default 8, giving the number of return-address stack entries (power of 2).
REQ-002 The block SHALL take parameter RAS_TARGET_WIDTH, default 12, giving the stored target width (matches BTB target width).
REQ-003 The block SHALL derive LOG_RAS_DEPTH = $clog2(RAS_DEPTH), default 3.
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 push_valid  input  1  push a call return address this cycle.
REQ-007 push_target  input  RAS_TARGET_WIDTH  return address to push.
REQ-008 pop_valid  input  1  pop for a return this cycle.
REQ-009 pop_target  output  RAS_TARGET_WIDTH  current top-of-stack entry, combinational.
REQ-010 pop_empty  output  1  high when count == 0.
REQ-011 ras_index  output  LOG_RAS_DEPTH  current top-of-stack pointer, for checkpointing.
REQ-012 ras_count  output  LOG_RAS_DEPTH+1  current valid entry count, for checkpointing.
REQ-013 restore_valid  input  1  restore pointer/count from a checkpoint (mispredict or flush).
REQ-014 restore_index  input  LOG_RAS_DEPTH  checkpointed pointer.
REQ-015 restore_count  input  LOG_RAS_DEPTH+1  checkpointed count; values above RAS_DEPTH SHALL be clamped to RAS_DEPTH.

Function
REQ-016 State SHALL be a circular array of RAS_DEPTH entries, pointer ptr (points at top entry), and count in 0..RAS_DEPTH.
REQ-017 pop_target SHALL equal array[ptr] every cycle, including when empty (stale data, no gating).
REQ-018 Push only: ptr <= ptr+1 mod RAS_DEPTH; array[ptr+1] <= push_target; count <= min(count+1, RAS_DEPTH).
REQ-019 Push when count == RAS_DEPTH SHALL overwrite the oldest entry, with count held at RAS_DEPTH.
REQ-020 Pop only: ptr <= ptr-1 mod RAS_DEPTH; count <= count-1 saturating at 0; array unchanged.
REQ-021 Pop when empty SHALL still decrement ptr (wraps 0 -> RAS_DEPTH-1) with count held at 0.
REQ-022 Push and pop in the same cycle SHALL replace the top: array[ptr] <= push_target, ptr unchanged, count <= max(count,1).
REQ-023 restore_valid SHALL override push_valid and pop_valid: ptr <= restore_index, count <= clamped restore_count, array unchanged.
REQ-024 All updates SHALL take effect on the next edge; pop_target reflects a new push one cycle after push_valid.
REQ-025 Pointer arithmetic SHALL be LOG_RAS_DEPTH-bit modular; count arithmetic SHALL be LOG_RAS_DEPTH+1 bits with saturation.
REQ-026 Idle cycles (no valid inputs) SHALL hold all state.

Reset
REQ-027 While RST is high at an edge: ptr <= 0, count <= 0, and all array entries <= 0; RST SHALL override restore, push and pop.
REQ-028 After reset: pop_target = 0, pop_empty = 1, ras_index = 0, ras_count = 0.
REQ-029 Reset asserted mid-sequence SHALL discard all pushed entries within one cycle.

Verification
REQ-030 Reset, push 0x111, 0x222, 0x333 -> ras_index 3, ras_count 3, pop_target 0x333; pop twice -> pop_target 0x111, ras_count 1.
REQ-031 Push 0x001..0x009 (9 pushes) -> ras_count 8, ras_index 1, pop_target 0x009; 8 pops return 0x009..0x002, then pop_empty 1.
REQ-032 Empty, pop -> ras_index 7, ras_count 0, pop_empty 1; then push 0xABC -> ras_index 0, ras_count 1, pop_target 0xABC.
REQ-033 Stack {0x111,0x222}, push 0x5A5 with pop same cycle -> ras_index 2, ras_count 2, pop_target 0x5A5, then pop -> 0x111.
REQ-034 Checkpoint (index 2, count 2), push 0x777, pop twice, then restore_valid with push_valid -> ras_index 2, ras_count 2, pop_target 0x222 (pop of 0x222 did not corrupt it; push ignored).
REQ-035 restore_count 15 with restore_index 4 -> ras_count 8, ras_index 4; RST asserted with push_valid -> all outputs at reset values next cycle.
